// File: rtl/ap_sequencer.sv
// ALU operation sequencer: accepts one request at a time, drives registered
// operands to an external ALU, holds them for HOLD_CYCLES cycles, captures
// the result and flags, and presents them on a valid/ready response port.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; req_ready=1
// ISSUE | operands held on alu_*; hold counter running down to capture
// RESP  | captured result presented; waiting for rsp_ready
module ap_sequencer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_use_carry,
    input  logic       flag_clr,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_aop,
    output logic       alu_cin,
    input  logic [7:0] alu_f,
    input  logic       alu_ovf,
    input  logic       alu_cout,
    input  logic       alu_n,
    input  logic       alu_z,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_f,
    output logic [3:0] rsp_flags,
    output logic       busy
);

    // Out-of-range hold values fall back to a single hold cycle.
    localparam int         HOLD_EFF  = (HOLD_CYCLES >= 1 && HOLD_CYCLES <= 4) ? HOLD_CYCLES : 1;
    localparam logic [1:0] HOLD_LOAD = 2'(HOLD_EFF - 1);
    localparam int         FLAG_C    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [2:0] alu_aop_q, alu_aop_d;
    logic       alu_cin_q, alu_cin_d;
    logic [1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] rsp_f_q, rsp_f_d;
    logic [3:0] rsp_flags_q, rsp_flags_d;
    logic [3:0] flags_q, flags_d;
    logic [3:0] alu_flags;

    assign alu_flags = {alu_cout, alu_ovf, alu_n, alu_z};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_aop_q   <= '0;
            alu_cin_q   <= 1'b0;
            hold_cnt_q  <= '0;
            rsp_f_q     <= '0;
            rsp_flags_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_aop_q   <= alu_aop_d;
            alu_cin_q   <= alu_cin_d;
            hold_cnt_q  <= hold_cnt_d;
            rsp_f_q     <= rsp_f_d;
            rsp_flags_q <= rsp_flags_d;
            flags_q     <= flags_d;
        end
    end

    // Next-state and datapath logic; a capture overrides a same-cycle flag clear,
    // and an accept reads the stored carry before any same-cycle clear lands.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_aop_d   = alu_aop_q;
        alu_cin_d   = alu_cin_q;
        hold_cnt_d  = hold_cnt_q;
        rsp_f_d     = rsp_f_q;
        rsp_flags_d = rsp_flags_q;
        flags_d     = flag_clr ? 4'b0000 : flags_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_a_d    = req_a;
                    alu_b_d    = req_b;
                    alu_aop_d  = req_op;
                    alu_cin_d  = req_use_carry & flags_q[FLAG_C];
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (hold_cnt_q == 2'd0) begin
                    rsp_f_d     = alu_f;
                    rsp_flags_d = alu_flags;
                    flags_d     = alu_flags;
                    state_d     = RESP;
                end else begin
                    hold_cnt_d = hold_cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_aop   = alu_aop_q;
    assign alu_cin   = alu_cin_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_ap_sequencer.sv
// Bench for ap_sequencer: three instances (hold 1, hold 3, out-of-range hold)
// each paired with a behavioural ALU, a transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ap_sequencer;

    localparam int N = 3;

    logic       clk;
    logic       reset         [N];
    logic       req_valid     [N];
    logic       req_ready     [N];
    logic [2:0] req_op        [N];
    logic [7:0] req_a         [N];
    logic [7:0] req_b         [N];
    logic       req_use_carry [N];
    logic       flag_clr      [N];
    logic [7:0] alu_a         [N];
    logic [7:0] alu_b         [N];
    logic [2:0] alu_aop       [N];
    logic       alu_cin       [N];
    logic [7:0] alu_f         [N];
    logic       alu_ovf       [N];
    logic       alu_cout      [N];
    logic       alu_n         [N];
    logic       alu_z         [N];
    logic       rsp_valid     [N];
    logic       rsp_ready     [N];
    logic [7:0] rsp_f         [N];
    logic [3:0] rsp_flags     [N];
    logic       busy          [N];

    logic       noise_en      [N];
    logic [7:0] noise_f       [N];
    logic [3:0] noise_fl      [N];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference ALU: returns {f, cout, ovf, n, z}.
    function automatic logic [11:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op, input logic cin);
        logic [8:0] s;
        logic       v;
        s = '0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                v = (a[7] == b[7]) && (s[7] != a[7]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 9'd1;
                v = (a[7] != b[7]) && (s[7] != a[7]);
            end
            3'd2: begin
                s = {1'b0, b} + {1'b0, ~a} + 9'd1;
                v = (a[7] != b[7]) && (s[7] != b[7]);
            end
            3'd3: s = {1'b0, a | b};
            3'd4: s = {1'b0, a & b};
            3'd5: s = {1'b0, ~a & b};
            3'd6: s = {1'b0, a ^ b};
            default: s = {1'b0, ~(a ^ b)};
        endcase
        return {s[7:0], s[8], v, s[7], (s[7:0] == 8'd0)};
    endfunction

    function automatic int eff_hold(input int i);
        int raw;
        raw = (i == 0) ? 1 : ((i == 1) ? 3 : 0);
        return (raw >= 1 && raw <= 4) ? raw : 1;
    endfunction

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_inst
            ap_sequencer #(.HOLD_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 0))) dut (
                .clk          (clk),
                .reset        (reset[g]),
                .req_valid    (req_valid[g]),
                .req_ready    (req_ready[g]),
                .req_op       (req_op[g]),
                .req_a        (req_a[g]),
                .req_b        (req_b[g]),
                .req_use_carry(req_use_carry[g]),
                .flag_clr     (flag_clr[g]),
                .alu_a        (alu_a[g]),
                .alu_b        (alu_b[g]),
                .alu_aop      (alu_aop[g]),
                .alu_cin      (alu_cin[g]),
                .alu_f        (alu_f[g]),
                .alu_ovf      (alu_ovf[g]),
                .alu_cout     (alu_cout[g]),
                .alu_n        (alu_n[g]),
                .alu_z        (alu_z[g]),
                .rsp_valid    (rsp_valid[g]),
                .rsp_ready    (rsp_ready[g]),
                .rsp_f        (rsp_f[g]),
                .rsp_flags    (rsp_flags[g]),
                .busy         (busy[g])
            );
            // ALU either computes from the sequencer's operands or emits noise.
            assign {alu_f[g], alu_cout[g], alu_ovf[g], alu_n[g], alu_z[g]} =
                noise_en[g] ? {noise_f[g], noise_fl[g]}
                            : alu_calc(alu_a[g], alu_b[g], alu_aop[g], alu_cin[g]);
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fresh noise every cycle so any sampling outside the capture cycle shows up.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            noise_f[i]  = 8'($urandom);
            noise_fl[i] = 4'($urandom);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting on the DUT", nm);
    endtask

    // Reference model state per instance.
    bit         m_known [N];
    bit         m_pend  [N];
    bit         m_resp  [N];
    int         m_acc   [N];
    logic [7:0] m_a     [N];
    logic [7:0] m_b     [N];
    logic [2:0] m_op    [N];
    logic       m_cin   [N];
    logic [7:0] m_f     [N];
    logic [3:0] m_fl    [N];
    logic [3:0] m_st    [N];

    // Compare every output against the model, then advance the model by one cycle.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            logic [11:0] cap;
            logic [3:0]  st_n;
            if (m_known[i]) begin
                chk($sformatf("i%0d req_ready", i), 32'(req_ready[i]), 32'(!(m_pend[i] || m_resp[i])));
                chk($sformatf("i%0d busy", i),      32'(busy[i]),      32'(m_pend[i] || m_resp[i]));
                chk($sformatf("i%0d rsp_valid", i), 32'(rsp_valid[i]), 32'(m_resp[i]));
                chk($sformatf("i%0d alu_a", i),     32'(alu_a[i]),     32'(m_a[i]));
                chk($sformatf("i%0d alu_b", i),     32'(alu_b[i]),     32'(m_b[i]));
                chk($sformatf("i%0d alu_aop", i),   32'(alu_aop[i]),   32'(m_op[i]));
                chk($sformatf("i%0d alu_cin", i),   32'(alu_cin[i]),   32'(m_cin[i]));
                chk($sformatf("i%0d rsp_f", i),     32'(rsp_f[i]),     32'(m_f[i]));
                chk($sformatf("i%0d rsp_flags", i), 32'(rsp_flags[i]), 32'(m_fl[i]));
            end
            if (reset[i] === 1'b1) begin
                m_known[i] = 1'b1;
                m_pend[i]  = 1'b0;
                m_resp[i]  = 1'b0;
                m_acc[i]   = 0;
                m_a[i]     = '0;
                m_b[i]     = '0;
                m_op[i]    = '0;
                m_cin[i]   = 1'b0;
                m_f[i]     = '0;
                m_fl[i]    = '0;
                m_st[i]    = '0;
            end else if (m_known[i]) begin
                st_n = flag_clr[i] ? 4'b0000 : m_st[i];
                if (!m_pend[i] && !m_resp[i]) begin
                    if (req_valid[i]) begin
                        m_a[i]    = req_a[i];
                        m_b[i]    = req_b[i];
                        m_op[i]   = req_op[i];
                        m_cin[i]  = req_use_carry[i] & m_st[i][3];
                        m_pend[i] = 1'b1;
                        m_acc[i]  = cyc;
                    end
                end else if (m_pend[i]) begin
                    if (cyc - m_acc[i] == eff_hold(i)) begin
                        cap = noise_en[i] ? {noise_f[i], noise_fl[i]}
                                          : alu_calc(m_a[i], m_b[i], m_op[i], m_cin[i]);
                        m_f[i]    = cap[11:4];
                        m_fl[i]   = cap[3:0];
                        st_n      = cap[3:0];
                        m_pend[i] = 1'b0;
                        m_resp[i] = 1'b1;
                    end
                end else if (rsp_ready[i]) begin
                    m_resp[i] = 1'b0;
                end
                m_st[i] = st_n;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns once accepted (at the start of the first ISSUE cycle).
    task automatic do_req(input int i, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic uc, output int acc_c);
        req_op[i]        = op;
        req_a[i]         = a;
        req_b[i]         = b;
        req_use_carry[i] = uc;
        req_valid[i]     = 1'b1;
        acc_c = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[i] === 1'b1) acc_c = cyc;
            step();
            if (acc_c >= 0) break;
        end
        req_valid[i] = 1'b0;
        if (acc_c < 0) timeout_fail($sformatf("i%0d accept", i));
    endtask

    // Waits for the response and consumes it (rsp_ready must be high).
    task automatic get_rsp(input int i, output logic [7:0] f, output logic [3:0] fl,
                           output int rsp_c);
        rsp_c = -1;
        f     = '0;
        fl    = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid[i] === 1'b1) begin
                f     = rsp_f[i];
                fl    = rsp_flags[i];
                rsp_c = cyc;
            end
            step();
            if (rsp_c >= 0) break;
        end
        if (rsp_c < 0) timeout_fail($sformatf("i%0d response", i));
    endtask

    task automatic run_op(input int i, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic uc,
                          output logic [7:0] f, output logic [3:0] fl, output int lat);
        int acc_c, rsp_c;
        do_req(i, op, a, b, uc, acc_c);
        get_rsp(i, f, fl, rsp_c);
        lat = rsp_c - acc_c;
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom % 8)
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h7F;
            3: return 8'h80;
            4: return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f;
        logic [3:0] fl;
        logic [7:0] rec [3];
        int lat, acc_c, rsp_c;
        bit got;

        for (int i = 0; i < N; i++) begin
            reset[i]         = 1'b1;
            req_valid[i]     = 1'b0;
            req_op[i]        = '0;
            req_a[i]         = '0;
            req_b[i]         = '0;
            req_use_carry[i] = 1'b0;
            flag_clr[i]      = 1'b0;
            rsp_ready[i]     = 1'b1;
            noise_en[i]      = 1'b0;
            noise_f[i]       = '0;
            noise_fl[i]      = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) reset[i] = 1'b0;

        @(negedge clk);
        chk("post-reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("post-reset busy",      32'(busy[0]),      32'd0);
        chk("post-reset req_ready", 32'(req_ready[0]), 32'd1);
        step();

        // Signed-overflow add with hold 1.
        run_op(0, 3'd0, 8'h7F, 8'h01, 1'b0, f, fl, lat);
        chk("add7F rsp_f", 32'(f), 32'h80);
        chk("add7F flags", 32'(fl), 32'b0110);
        chk("add7F latency", 32'(lat), 32'd2);

        run_op(0, 3'd1, 8'h05, 8'h05, 1'b0, f, fl, lat);
        chk("sub55 rsp_f", 32'(f), 32'h00);
        chk("sub55 flags", 32'(fl), 32'b1001);

        // Carry chain.
        run_op(0, 3'd0, 8'hFF, 8'h01, 1'b0, f, fl, lat);
        chk("addFF flags", 32'(fl), 32'b1001);
        do_req(0, 3'd0, 8'h00, 8'h00, 1'b1, acc_c);
        @(negedge clk);
        chk("chain alu_cin", 32'(alu_cin[0]), 32'd1);
        get_rsp(0, f, fl, rsp_c);
        chk("chain rsp_f", 32'(f), 32'h01);

        // Same chain after a flag clear pulse.
        run_op(0, 3'd0, 8'hFF, 8'h01, 1'b0, f, fl, lat);
        flag_clr[0] = 1'b1;
        step();
        flag_clr[0] = 1'b0;
        do_req(0, 3'd0, 8'h00, 8'h00, 1'b1, acc_c);
        @(negedge clk);
        chk("cleared alu_cin", 32'(alu_cin[0]), 32'd0);
        get_rsp(0, f, fl, rsp_c);
        chk("cleared rsp_f", 32'(f), 32'h00);

        // Flag clear coinciding with accept still uses the old carry.
        run_op(0, 3'd0, 8'hFF, 8'h01, 1'b0, f, fl, lat);
        flag_clr[0] = 1'b1;
        do_req(0, 3'd0, 8'h00, 8'h00, 1'b1, acc_c);
        flag_clr[0] = 1'b0;
        @(negedge clk);
        chk("clr@accept alu_cin", 32'(alu_cin[0]), 32'd1);
        get_rsp(0, f, fl, rsp_c);
        chk("clr@accept rsp_f", 32'(f), 32'h01);

        // Flag clear coinciding with capture loses to the captured flags.
        do_req(0, 3'd0, 8'hFF, 8'h01, 1'b0, acc_c);
        flag_clr[0] = 1'b1;
        step();
        flag_clr[0] = 1'b0;
        get_rsp(0, f, fl, rsp_c);
        chk("clr@capture flags", 32'(fl), 32'b1001);
        run_op(0, 3'd0, 8'h00, 8'h00, 1'b1, f, fl, lat);
        chk("clr@capture next rsp_f", 32'(f), 32'h01);

        // Backpressure with a pending request waiting.
        rsp_ready[0] = 1'b0;
        do_req(0, 3'd0, 8'h03, 8'h04, 1'b0, acc_c);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid[0] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail("bp response");
        step();
        req_op[0] = 3'd0;
        req_a[0] = 8'h10;
        req_b[0] = 8'h20;
        req_use_carry[0] = 1'b0;
        req_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp rsp_valid", 32'(rsp_valid[0]), 32'd1);
            chk("bp rsp_f",     32'(rsp_f[0]),     32'h07);
            chk("bp rsp_flags", 32'(rsp_flags[0]), 32'b0000);
            chk("bp req_ready", 32'(req_ready[0]), 32'd0);
            step();
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("b2b idle rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("b2b idle req_ready", 32'(req_ready[0]), 32'd1);
        acc_c = cyc;
        step();
        @(negedge clk);
        chk("b2b accepted busy", 32'(busy[0]), 32'd1);
        step();
        req_valid[0] = 1'b0;
        get_rsp(0, f, fl, rsp_c);
        chk("b2b rsp_f", 32'(f), 32'h30);
        chk("b2b latency", 32'(rsp_c - acc_c), 32'd2);

        // Hold 3: plain latency.
        run_op(1, 3'd0, 8'h12, 8'h34, 1'b0, f, fl, lat);
        chk("h3 rsp_f", 32'(f), 32'h46);
        chk("h3 latency", 32'(lat), 32'd4);

        // Hold 3 with an ALU whose outputs change every ISSUE cycle.
        noise_en[1] = 1'b1;
        do_req(1, 3'd6, 8'hAA, 8'h55, 1'b0, acc_c);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rec[k] = noise_f[1];
        end
        get_rsp(1, f, fl, rsp_c);
        noise_en[1] = 1'b0;
        chk("h3 noise rsp_f", 32'(f), 32'(rec[2]));
        chk("h3 noise latency", 32'(rsp_c - acc_c), 32'd4);

        // Reset during ISSUE.
        run_op(1, 3'd0, 8'hFF, 8'h02, 1'b0, f, fl, lat);
        chk("h3 addFF02 rsp_f", 32'(f), 32'h01);
        do_req(1, 3'd0, 8'h00, 8'h00, 1'b1, acc_c);
        reset[1] = 1'b1;
        step();
        reset[1] = 1'b0;
        @(negedge clk);
        chk("midrst busy",      32'(busy[1]),      32'd0);
        chk("midrst req_ready", 32'(req_ready[1]), 32'd1);
        chk("midrst rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("midrst alu_cin",   32'(alu_cin[1]),   32'd0);
        chk("midrst rsp_f",     32'(rsp_f[1]),     32'h00);
        chk("midrst rsp_flags", 32'(rsp_flags[1]), 32'h0);
        step();
        do_req(1, 3'd0, 8'h00, 8'h00, 1'b1, acc_c);
        @(negedge clk);
        chk("midrst carry gone", 32'(alu_cin[1]), 32'd0);
        get_rsp(1, f, fl, rsp_c);
        chk("midrst next rsp_f", 32'(f), 32'h00);

        // Out-of-range hold behaves as hold 1.
        run_op(2, 3'd2, 8'h03, 8'h10, 1'b0, f, fl, lat);
        chk("h0 rsp_f", 32'(f), 32'h0D);
        chk("h0 latency", 32'(lat), 32'd2);

        // Randomized traffic on all instances, checked by the model.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i]     = ($urandom % 3) != 0;
                req_op[i]        = 3'($urandom);
                req_a[i]         = pick8();
                req_b[i]         = pick8();
                req_use_carry[i] = 1'($urandom);
                flag_clr[i]      = ($urandom % 12) == 0;
                rsp_ready[i]     = ($urandom % 4) != 0;
                noise_en[i]      = ($urandom % 6) == 0;
                reset[i]         = ($urandom % 200) == 0;
            end
            step();
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0;
            flag_clr[i]  = 1'b0;
            reset[i]     = 1'b0;
            rsp_ready[i] = 1'b1;
            noise_en[i]  = 1'b0;
        end
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ap_sequencer.md
AP_SEQUENCER -- requirements
Module: ap_sequencer

Interface
REQ-001 The block SHALL have one parameter: HOLD_CYCLES, default 1, the number of cycles (1..4) that ALU operands are held stable before results are sampled.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  the single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  operation request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  ALU operation code: 000 add, 001 a-b, 010 b-a, 011 or, 100 and, 101 ~a&b, 110 xor, 111 xnor.
- req_a  in  8  operand A.
- req_b  in  8  operand B.
- req_use_carry  in  1  drive the stored carry flag as ALU carry-in.
- flag_clr  in  1  clear all four stored flags.
- alu_a  out  8  registered operand A to the ALU.
- alu_b  out  8  registered operand B to the ALU.
- alu_aop  out  3  registered operation code to the ALU.
- alu_cin  out  1  registered carry-in to the ALU.
- alu_f  in  8  ALU result.
- alu_ovf  in  1  ALU overflow.
- alu_cout  in  1  ALU carry-out.
- alu_n  in  1  ALU negative.
- alu_z  in  1  ALU zero.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_f  out  8  captured result.
- rsp_flags  out  4  captured flags {C,V,N,Z}.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The block SHALL implement the states IDLE, ISSUE and RESP.
REQ-004 In IDLE, req_ready SHALL be 1; in every other state req_ready SHALL be 0, and req_valid SHALL be ignored.
REQ-005 On a cycle with req_valid and req_ready both high (accept), the block SHALL register req_a, req_b and req_op onto alu_a, alu_b and alu_aop, SHALL set alu_cin = req_use_carry AND the stored C flag, SHALL load the hold counter with HOLD_CYCLES-1, and SHALL enter ISSUE.
REQ-006 In ISSUE, alu_a, alu_b, alu_aop and alu_cin SHALL remain unchanged, and the hold counter SHALL decrement once per cycle.
REQ-007 On the ISSUE cycle where the hold counter equals 0 (the capture cycle), the block SHALL load rsp_f from alu_f and rsp_flags from {alu_cout, alu_ovf, alu_n, alu_z}, SHALL update the stored flags from the same values, and SHALL enter RESP.
REQ-008 Latency: with HOLD_CYCLES=H, rsp_valid SHALL rise exactly H+1 cycles after the accept edge.
REQ-009 In RESP, rsp_valid SHALL be 1 and rsp_f and rsp_flags SHALL be held stable until rsp_valid and rsp_ready are both high.
REQ-010 On the rsp_valid/rsp_ready handshake, the block SHALL return to IDLE, and rsp_valid SHALL be 0 on the next cycle.
REQ-011 Back-to-back requests SHALL incur exactly one IDLE cycle between a response handshake and the next accept.
REQ-012 The stored flags SHALL be updated on every capture regardless of operation code, so logic operations leave C=0 and V=0 as reported by the ALU.
REQ-013 A flag_clr pulse SHALL zero the stored flags on the next edge; flag_clr SHALL NOT alter rsp_flags.
REQ-014 If flag_clr and the capture cycle coincide, the captured ALU flags SHALL win.
REQ-015 If flag_clr and an accept coincide, alu_cin SHALL use the pre-clear C value.
REQ-016 The ALU outputs SHALL be sampled only on the capture cycle and SHALL be ignored at all other times.
REQ-017 A HOLD_CYCLES value outside 1..4 SHALL be treated as 1.

Reset
REQ-018 Reset SHALL take priority over all other inputs and, including when asserted in the middle of an operation, SHALL force the block to IDLE.
REQ-019 Reset SHALL zero alu_a, alu_b, alu_aop, alu_cin, rsp_f, rsp_flags, the stored flags and the hold counter.
REQ-020 After reset, rsp_valid=0, busy=0 and req_ready=1 SHALL hold on the first cycle following reset deassertion.

Verification
REQ-021 Add case: req_op=000, a=0x7F, b=0x01, H=1 -> rsp_valid at accept+2, rsp_f=0x80, rsp_flags=0110 (C=0, V=1, N=1, Z=0).
REQ-022 Subtract case: req_op=001, a=0x05, b=0x05 -> rsp_f=0x00, Z=1, C=1.
REQ-023 Carry chain: add 0xFF+0x01 (C=1), then add 0x00+0x00 with req_use_carry=1 -> alu_cin=1 and rsp_f=0x01; repeating after a flag_clr pulse -> rsp_f=0x00.
REQ-024 Backpressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_f and rsp_flags remain stable, and req_ready stays 0 with req_valid=1 throughout.
REQ-025 Hold timing: H=3 with alu_f changing in every ISSUE cycle -> rsp_f equals the alu_f value from the third ISSUE cycle, and rsp_valid rises at accept+4.
REQ-026 Mid-operation reset: assert reset in the ISSUE cycle -> next cycle is IDLE with all outputs at their reset values, and the stored C flag is 0.
